// File: rtl/csa_mul_pipe.sv
// Pipelined Baugh-Wooley carry-save array multiplier with a valid/ready handshake.
// Partial-product rows are folded into a sum/carry pair across PIPE registered stages.
module csa_mul_pipe #(
  parameter int WIDTH = 8,
  parameter int PIPE  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int PW    = 2 * WIDTH;
  localparam int NROWS = WIDTH + 1;
  localparam int LAT   = PIPE + 2;

  if (WIDTH < 4 || WIDTH > 32 || PIPE < 1 || PIPE > WIDTH - 1 || LAT != PIPE + 2) begin : g_param_check
    $error("csa_mul_pipe: WIDTH must be 4..32 and PIPE 1..WIDTH-1");
  end

  // Row i < WIDTH is a & b[i]; in signed mode the cross terms with exactly one
  // sign bit are inverted. Row WIDTH carries the 2^W + 2^(2W-1) correction.
  function automatic logic [PW-1:0] pp_row(input logic [WIDTH-1:0] x,
                                           input logic [WIDTH-1:0] y,
                                           input logic sg, input int i);
    logic [PW-1:0] row;
    logic          bt;
    row = '0;
    if (i == WIDTH) begin
      if (sg) begin
        row[WIDTH] = 1'b1;
        row[PW-1]  = 1'b1;
      end
    end else begin
      for (int j = 0; j < WIDTH; j++) begin
        bt = x[j] & y[i];
        if (sg && ((j == WIDTH - 1) != (i == WIDTH - 1))) bt = ~bt;
        row[i+j] = bt;
      end
    end
    return row;
  endfunction

  function automatic logic [2*PW-1:0] csa3(input logic [PW-1:0] x, y, z);
    logic [PW-1:0] sum, cy;
    sum = x ^ y ^ z;
    cy  = ((x & y) | (x & z) | (y & z)) << 1;
    return {sum, cy};
  endfunction

  function automatic logic [2*PW-1:0] reduce(input logic [PW-1:0] s, c,
                                             input logic [WIDTH-1:0] x, y,
                                             input logic sg, input int r0, r1);
    logic [2*PW-1:0] sc;
    sc = {s, c};
    for (int r = r0; r < r1; r++)
      sc = csa3(sc[2*PW-1:PW], sc[PW-1:0], pp_row(x, y, sg, r));
    return sc;
  endfunction

  logic                 en;
  logic [PIPE:0]        vld_p;
  logic [WIDTH-1:0]     a_p [PIPE];
  logic [WIDTH-1:0]     b_p [PIPE];
  logic [PIPE-1:0]      sg_p;
  logic [PW-1:0]        s_p [PIPE];
  logic [PW-1:0]        c_p [PIPE];
  logic [PW-1:0]        s_nxt [PIPE];
  logic [PW-1:0]        c_nxt [PIPE];

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Reduction stage k folds its share of rows into the sum/carry from stage k-1
  for (genvar k = 0; k < PIPE; k++) begin : g_stage
    localparam int R0 = (k * NROWS) / PIPE;
    localparam int R1 = ((k + 1) * NROWS) / PIPE;
    if (k == 0) begin : g_head
      assign {s_nxt[k], c_nxt[k]} = reduce('0, '0, a_p[k], b_p[k], sg_p[k], R0, R1);
    end else begin : g_tail
      assign {s_nxt[k], c_nxt[k]} = reduce(s_p[k-1], c_p[k-1], a_p[k], b_p[k], sg_p[k], R0, R1);
    end
  end

  // Control and output stage: valid bits, out_valid, p
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p     <= '0;
      out_valid <= 1'b0;
      p         <= '0;
    end else if (en) begin
      vld_p     <= {vld_p[PIPE-1:0], in_valid};
      out_valid <= vld_p[PIPE];
      if (vld_p[PIPE]) p <= s_p[PIPE-1] + c_p[PIPE-1];
    end
  end

  // Input stage p0 and reduction stage registers
  always_ff @(posedge clk) begin
    if (en) begin
      a_p[0]  <= a;
      b_p[0]  <= b;
      sg_p[0] <= is_signed;
      for (int k = 0; k < PIPE - 1; k++) begin
        a_p[k+1]  <= a_p[k];
        b_p[k+1]  <= b_p[k];
        sg_p[k+1] <= sg_p[k];
      end
      for (int k = 0; k < PIPE; k++) begin
        s_p[k] <= s_nxt[k];
        c_p[k] <= c_nxt[k];
      end
    end
  end

endmodule
